// File: rtl/clk_div_monitor_if.sv
// rtl/clk_div_monitor_if.sv - signal bundle between a divided-clock source and its monitor
//
// Ports (as seen through modport slave, i.e. by the monitor):
//   i_mon_en      in   monitor enable
//   i_div_clk     in   divided clock under test, sampled as data
//   i_exp_ratio   in   expected divide ratio
//   o_meas_ratio  out  last measured period in reference cycles
//   o_meas_high   out  last measured high time in reference cycles
//   o_valid       out  one-cycle pulse per new measurement
//   o_mismatch    out  measured period differs from expected ratio
//   o_duty_err    out  high time outside the allowed range
//   o_cfg_err     out  expected ratio below 2
//   o_stuck       out  no rising edge within the timeout window
// modport master is the driving side (system or bench).
interface clk_div_monitor_if #(
  parameter int CNT_W = 32
);
  logic             i_mon_en;
  logic             i_div_clk;
  logic [CNT_W-1:0] i_exp_ratio;
  logic [CNT_W-1:0] o_meas_ratio;
  logic [CNT_W-1:0] o_meas_high;
  logic             o_valid;
  logic             o_mismatch;
  logic             o_duty_err;
  logic             o_cfg_err;
  logic             o_stuck;

  modport master (
    output i_mon_en, i_div_clk, i_exp_ratio,
    input  o_meas_ratio, o_meas_high, o_valid, o_mismatch,
           o_duty_err, o_cfg_err, o_stuck
  );

  modport slave (
    input  i_mon_en, i_div_clk, i_exp_ratio,
    output o_meas_ratio, o_meas_high, o_valid, o_mismatch,
           o_duty_err, o_cfg_err, o_stuck
  );
endinterface

// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - measures period and high time of a divided clock against its ratio
//
// Ports:
//   i_ref_clk  in  reference clock, all logic on its rising edge
//   i_rst      in  asynchronous active-high reset
//   mon_if     slave modport of clk_div_monitor_if (enable, divided clock,
//              expected ratio in; measurement, valid and error flags out)
// Parameters:
//   CNT_W        width of the counters and measurement outputs
//   TIMEOUT_CYC  reference cycles without a rising edge before o_stuck sets
module clk_div_monitor #(
  parameter int CNT_W       = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic             i_ref_clk,
  input logic             i_rst,
  clk_div_monitor_if.slave mon_if
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SYNC    = 2'd1,
    ST_MEASURE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO         = CNT_W'(2);

  state_t           r_state;
  state_t           w_state_next;

  logic             r_s0;
  logic             r_s1;
  logic             w_rise;

  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic [CNT_W-1:0] r_meas_ratio;
  logic [CNT_W-1:0] r_meas_high;
  logic             r_valid;
  logic             r_mismatch;
  logic             r_duty_err;
  logic             r_cfg_err;
  logic             r_stuck;

  logic             w_clear;
  logic             w_lock;
  logic             w_capture;
  logic             w_count;
  logic             w_cfg_bad;
  logic [CNT_W-1:0] w_exp_half;
  logic             w_duty_ok;

  assign w_rise     = r_s0 & ~r_s1;
  assign w_cfg_bad  = (mon_if.i_exp_ratio < TWO);
  assign w_exp_half = mon_if.i_exp_ratio >> 1;
  // Even ratio needs exactly half; odd ratio accepts floor or ceil of half.
  assign w_duty_ok  = (r_high_cnt == w_exp_half) ||
                      (mon_if.i_exp_ratio[0] && (r_high_cnt == w_exp_half + ONE));

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Dropping the enable clears everything on the same edge it returns to IDLE,
  // so a stale o_stuck never outlives the disable.
  always_comb begin
    w_state_next = r_state;
    w_clear      = ~mon_if.i_mon_en;
    w_lock       = 1'b0;
    w_capture    = 1'b0;
    w_count      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_clear = 1'b1;
        if (mon_if.i_mon_en) begin
          w_state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (!mon_if.i_mon_en) begin
          w_state_next = ST_IDLE;
        end else if (w_rise) begin
          // First edge after enabling closes a partial period: lock only.
          w_lock       = 1'b1;
          w_state_next = ST_MEASURE;
        end else begin
          w_count = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!mon_if.i_mon_en) begin
          w_state_next = ST_IDLE;
        end else if (w_rise) begin
          w_capture = 1'b1;
        end else begin
          w_count = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_ref_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s0         <= 1'b0;
      r_s1         <= 1'b0;
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_meas_ratio <= '0;
      r_meas_high  <= '0;
      r_valid      <= 1'b0;
      r_mismatch   <= 1'b0;
      r_duty_err   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_stuck      <= 1'b0;
    end else begin
      r_s0      <= mon_if.i_div_clk;
      r_s1      <= r_s0;
      r_cfg_err <= w_cfg_bad;
      r_valid   <= w_capture;

      if (w_clear) begin
        r_period_cnt <= '0;
        r_high_cnt   <= '0;
        r_stuck      <= 1'b0;
      end else if (w_lock || w_capture) begin
        // The rise cycle itself is high and is the first cycle of the new period.
        r_period_cnt <= ONE;
        r_high_cnt   <= ONE;
        r_stuck      <= 1'b0;
      end else if (w_count) begin
        // In SYNC the period counter doubles as the wait-for-first-edge timer.
        if (r_period_cnt != CNT_MAX) begin
          r_period_cnt <= r_period_cnt + ONE;
        end
        if (r_s0 && (r_high_cnt != CNT_MAX)) begin
          r_high_cnt <= r_high_cnt + ONE;
        end
        if (r_period_cnt >= TIMEOUT_VAL) begin
          r_stuck <= 1'b1;
        end
      end

      if (w_capture) begin
        r_meas_ratio <= r_period_cnt;
        r_meas_high  <= r_high_cnt;
        r_mismatch   <= ~w_cfg_bad && (r_period_cnt != mon_if.i_exp_ratio);
        r_duty_err   <= ~w_cfg_bad && ~w_duty_ok;
      end
    end
  end

  assign mon_if.o_meas_ratio = r_meas_ratio;
  assign mon_if.o_meas_high  = r_meas_high;
  assign mon_if.o_valid      = r_valid;
  assign mon_if.o_mismatch   = r_mismatch;
  assign mon_if.o_duty_err   = r_duty_err;
  assign mon_if.o_cfg_err    = r_cfg_err;
  assign mon_if.o_stuck      = r_stuck;

endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - scoreboard bench for clk_div_monitor
module tb_clk_div_monitor;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int SAT     = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  clk_div_monitor_if #(.CNT_W(CNT_W)) mon_if ();

  clk_div_monitor #(
    .CNT_W      (CNT_W),
    .TIMEOUT_CYC(TIMEOUT)
  ) dut (
    .i_ref_clk(clk),
    .i_rst    (rst),
    .mon_if   (mon_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ratio;
    int high;
    bit mism;
    bit duty;
  } meas_t;

  typedef struct {
    bit stuck;
    bit cfg;
  } cyc_t;

  meas_t exp_q[$];
  cyc_t  cyc_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: driven waveform history and lock bookkeeping.
  bit lvl[0:16383];
  int gc = 0;
  bit l1 = 0, l2 = 0, en1 = 0, locked = 0;
  int r_prev = 0;
  int s_start = 0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit duty_ok(input int h, input int e);
    if (e % 2 == 0) return (2 * h == e);
    return (2 * h == e - 1) || (2 * h == e + 1);
  endfunction

  task automatic model_reset();
    l1 = 0; l2 = 0; en1 = 0; locked = 0;
  endtask

  // One reference cycle: apply inputs at the falling edge, predict what the
  // monitor must show after the following rising edge.
  task automatic drive(input bit lv, input bit en, input int ex);
    bit    counted;
    bit    stk;
    int    r;
    int    h;
    meas_t m;
    cyc_t  c;
    @(negedge clk);
    rst                = 1'b0;
    mon_if.i_div_clk   = lv;
    mon_if.i_mon_en    = en;
    mon_if.i_exp_ratio = CNT_W'(ex);

    // A rise of the previous cycle counts when enable was high during it and now.
    counted = l1 && !l2 && en1 && en;
    if (counted) begin
      r = gc - 1;
      if (locked) begin
        h = 0;
        for (int k = r_prev; k < r; k++) h += int'(lvl[k]);
        m.ratio = min_i(r - r_prev, SAT);
        m.high  = min_i(h, SAT);
        m.mism  = (ex >= 2) && (m.ratio != ex);
        m.duty  = (ex >= 2) && !duty_ok(m.high, ex);
        exp_q.push_back(m);
      end
      locked = 1;
      r_prev = r;
    end
    if (!en) locked = 0;
    if (en && !en1) s_start = gc;
    if (!en || counted)  stk = 0;
    else if (locked)     stk = (gc >= r_prev + TIMEOUT + 1);
    else                 stk = (gc >= s_start + TIMEOUT + 1);
    c.stuck = stk;
    c.cfg   = (ex < 2);
    cyc_q.push_back(c);

    lvl[gc] = lv;
    l2 = l1; l1 = lv; en1 = en;
    gc++;
  endtask

  task automatic run_periods(input int n, input int h, input int ex, input int cnt);
    for (int p = 0; p < cnt; p++)
      for (int k = 0; k < n; k++) drive(k < h, 1'b1, ex);
  endtask

  task automatic do_reset(input int ncyc);
    @(negedge clk);
    rst                = 1'b1;
    mon_if.i_mon_en    = 1'b1;
    mon_if.i_exp_ratio = CNT_W'(1);
    model_reset();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      mon_if.i_div_clk = ~mon_if.i_div_clk;
      @(posedge clk);
      #1;
      n_vec++;
      if (mon_if.o_meas_ratio !== '0 || mon_if.o_meas_high !== '0 || mon_if.o_valid !== 1'b0 ||
          mon_if.o_mismatch !== 1'b0 || mon_if.o_duty_err !== 1'b0 ||
          mon_if.o_cfg_err !== 1'b0 || mon_if.o_stuck !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: got ratio=%0d high=%0d valid=%b mism=%b duty=%b cfg=%b stuck=%b, want all 0",
                 mon_if.o_meas_ratio, mon_if.o_meas_high, mon_if.o_valid, mon_if.o_mismatch,
                 mon_if.o_duty_err, mon_if.o_cfg_err, mon_if.o_stuck);
      end
    end
  endtask

  // Monitor: per-cycle flags and measurement scoreboard.
  initial begin
    cyc_t  ce;
    meas_t me;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        ce = cyc_q.pop_front();
        n_vec++;
        if (mon_if.o_stuck !== ce.stuck || mon_if.o_cfg_err !== ce.cfg) begin
          n_err++;
          $display("FAIL flags t=%0t: got stuck=%b cfg=%b, want stuck=%b cfg=%b",
                   $time, mon_if.o_stuck, mon_if.o_cfg_err, ce.stuck, ce.cfg);
        end
      end
      if (mon_if.o_valid !== 1'b0) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_valid t=%0t: got valid=%b ratio=%0d, want no valid",
                   $time, mon_if.o_valid, mon_if.o_meas_ratio);
        end else begin
          me = exp_q.pop_front();
          if (mon_if.o_valid !== 1'b1 || int'(mon_if.o_meas_ratio) != me.ratio ||
              int'(mon_if.o_meas_high) != me.high || mon_if.o_mismatch !== me.mism ||
              mon_if.o_duty_err !== me.duty) begin
            n_err++;
            $display("FAIL meas t=%0t: got ratio=%0d high=%0d mism=%b duty=%b, want ratio=%0d high=%0d mism=%b duty=%b",
                     $time, mon_if.o_meas_ratio, mon_if.o_meas_high, mon_if.o_mismatch,
                     mon_if.o_duty_err, me.ratio, me.high, me.mism, me.duty);
          end
        end
      end
    end
  end

  initial begin
    int n, h, ex;
    bit en;
    mon_if.i_div_clk   = 1'b0;
    mon_if.i_mon_en    = 1'b0;
    mon_if.i_exp_ratio = '0;

    do_reset(6);

    // Ratio 2, 40 cycles.
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 2);
    run_periods(2, 1, 2, 20);

    // Ratio 5 with jittering high time, then wrong expected ratio.
    for (int p = 0; p < 6; p++) run_periods(5, int'($urandom_range(2, 3)), 5, 1);
    for (int p = 0; p < 4; p++) run_periods(5, int'($urandom_range(2, 3)), 4, 1);

    // Duty error: period 6, high 1.
    run_periods(6, 1, 6, 5);

    // Stuck clock, then a long stall that saturates the period counter.
    run_periods(3, 1, 3, 3);
    for (int i = 0; i < 40; i++) drive(1'b0, 1'b1, 3);
    run_periods(3, 1, 3, 3);
    for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 3);
    run_periods(3, 1, 3, 3);

    // Config error.
    run_periods(4, 2, 1, 4);
    run_periods(4, 2, 0, 3);

    // Disable mid-period, re-enable.
    run_periods(4, 2, 4, 3);
    drive(1'b1, 1'b1, 4);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 4);
    run_periods(4, 2, 4, 5);

    // Reset mid-measurement.
    run_periods(5, 2, 5, 2);
    drive(1'b1, 1'b1, 5);
    do_reset(3);
    run_periods(5, 2, 5, 4);

    // Randomized periods, expected ratios, enable drops and mid-period ratio changes.
    for (int p = 0; p < 60; p++) begin
      n  = int'($urandom_range(2, 12));
      h  = int'($urandom_range(1, n - 1));
      ex = ($urandom_range(0, 1) == 0) ? n : int'($urandom_range(0, 13));
      for (int k = 0; k < n; k++) begin
        en = ($urandom_range(0, 29) != 0);
        if ($urandom_range(0, 7) == 0) ex = int'($urandom_range(0, 13));
        drive(k < h, en, ex);
      end
    end

    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 3);
    @(negedge clk);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_valid: got %0d unconsumed expectations, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
